led_bank: RTL and testbench

Parametrised multi-channel LED driver. It is the successor to the single-output fixed-rate blinker. A shared prescaler generates a slow tick. Each of `N_CH` channels is independently configured through a simple write port as OFF, ON, BLINK or PWM, with its own period and duty. The block sits between the board-level LED pins and any control logic or CPU-side register file.

---
 rtl/led_pkg.sv | 19 +
 rtl/led_channel.sv | 100 ++++++++++
 rtl/led_bank.sv | 59 +++++
 tb/tb_led_bank.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and helpers for the multi-channel LED driver.
// Mode encoding matches the 2-bit cfg_mode field of the write port.
package led_pkg;

    localparam int LED_MODE_W = 2;

    typedef enum logic [LED_MODE_W-1:0] {
        LED_OFF   = 2'd0,
        LED_ON    = 2'd1,
        LED_BLINK = 2'd2,
        LED_PWM   = 2'd3
    } led_mode_t;

    // Index width that stays at least one bit wide for single-entry ranges.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: holds its own mode, period, duty, tick counter and blink phase.
// Advances only on the shared prescaler tick; a write restarts it from a known state.
module led_channel import led_pkg::*; #(
    parameter int PER_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             we,
    input  led_mode_t        mode,
    input  logic [PER_W-1:0] period,
    input  logic [PER_W-1:0] duty,
    output logic             led
);

    led_mode_t        mode_q, mode_d;
    logic [PER_W-1:0] period_q, period_d;
    logic [PER_W-1:0] duty_q, duty_d;
    logic [PER_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic             led_q, led_d;
    logic [PER_W-1:0] pe;
    logic             at_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q   <= LED_OFF;
            period_q <= '0;
            duty_q   <= '0;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
            led_q    <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            period_q <= period_d;
            duty_q   <= duty_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            led_q    <= led_d;
        end
    end

    // A zero period behaves as one so the counter always has a valid wrap point.
    always_comb begin
        pe      = (period_q == '0) ? PER_W'(1) : period_q;
        at_last = (cnt_q == pe - 1'b1);
    end

    // A write restarts the channel and takes priority over a coincident tick.
    always_comb begin
        mode_d   = mode_q;
        period_d = period_q;
        duty_d   = duty_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        if (we) begin
            mode_d   = mode;
            period_d = period;
            duty_d   = duty;
            cnt_d    = '0;
            phase_d  = 1'b0;
        end else begin
            case (mode_q)
                LED_BLINK: begin
                    if (tick) begin
                        if (at_last) begin
                            cnt_d   = '0;
                            phase_d = ~phase_q;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                LED_PWM: begin
                    phase_d = 1'b0;
                    if (tick) begin
                        cnt_d = at_last ? '0 : cnt_q + 1'b1;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    phase_d = 1'b0;
                end
            endcase
        end
    end

    // PWM compares the registered count, so the output trails the counter by a clock.
    always_comb begin
        case (mode_q)
            LED_ON:    led_d = 1'b1;
            LED_BLINK: led_d = phase_q;
            LED_PWM:   led_d = (cnt_q < duty_q);
            default:   led_d = 1'b0;
        endcase
    end

    assign led = led_q;

endmodule

// File: rtl/led_bank.sv
// Multi-channel LED driver: free-running prescaler tick, write decode and N_CH channels.
// Writes to channel indices at or above N_CH match no channel and are dropped.
module led_bank import led_pkg::*; #(
    parameter int N_CH     = 4,
    parameter int PER_W    = 8,
    parameter int PRESCALE = 50000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_we,
    input  logic [idx_w(N_CH)-1:0]  cfg_ch,
    input  logic [LED_MODE_W-1:0]   cfg_mode,
    input  logic [PER_W-1:0]        cfg_period,
    input  logic [PER_W-1:0]        cfg_duty,
    output logic [N_CH-1:0]         led
);

    localparam int                CH_W      = idx_w(N_CH);
    localparam int                PCNT_W    = idx_w(PRESCALE);
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PRESCALE - 1);

    logic [PCNT_W-1:0] pcnt_q, pcnt_d;
    logic              tick_q, tick_d;
    logic [N_CH-1:0]   ch_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_q <= '0;
            tick_q <= 1'b0;
        end else begin
            pcnt_q <= pcnt_d;
            tick_q <= tick_d;
        end
    end

    // tick is registered from the next count so it is high exactly while pcnt == PRESCALE-1.
    always_comb begin
        pcnt_d = (pcnt_q == PCNT_LAST) ? '0 : pcnt_q + 1'b1;
        tick_d = (pcnt_d == PCNT_LAST);
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign ch_we[i] = cfg_we && (cfg_ch == CH_W'(i));

        led_channel #(
            .PER_W (PER_W)
        ) u_channel (
            .clk    (clk),
            .rst    (rst),
            .tick   (tick_q),
            .we     (ch_we[i]),
            .mode   (led_mode_t'(cfg_mode)),
            .period (cfg_period),
            .duty   (cfg_duty),
            .led    (led[i])
        );
    end

endmodule

// File: tb/tb_led_bank.sv
// Bench for led_bank: a PRESCALE=4 instance checked every cycle against a closed-form
// tick model, plus a five-channel PRESCALE=1 instance for invalid-index and write-on-tick cases.
module tb_led_bank;
    import led_pkg::*;

    localparam int P4 = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       cfg4_we;
    logic [1:0] cfg4_ch;
    logic [1:0] cfg4_mode;
    logic [7:0] cfg4_period;
    logic [7:0] cfg4_duty;
    logic [3:0] led4;

    logic       cfg1_we;
    logic [2:0] cfg1_ch;
    logic [1:0] cfg1_mode;
    logic [7:0] cfg1_period;
    logic [7:0] cfg1_duty;
    logic [4:0] led1;

    led_bank #(.N_CH(4), .PER_W(8), .PRESCALE(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg4_we),
        .cfg_ch     (cfg4_ch),
        .cfg_mode   (cfg4_mode),
        .cfg_period (cfg4_period),
        .cfg_duty   (cfg4_duty),
        .led        (led4)
    );

    led_bank #(.N_CH(5), .PER_W(8), .PRESCALE(1)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg1_we),
        .cfg_ch     (cfg1_ch),
        .cfg_mode   (cfg1_mode),
        .cfg_period (cfg1_period),
        .cfg_duty   (cfg1_duty),
        .led        (led1)
    );

    int checks = 0;
    int errors = 0;

    // Reference model for dut4: per-channel config and the edge number that captured it.
    typedef struct packed {
        logic [1:0] mode;
        logic [7:0] period;
        logic [7:0] duty;
        int         w;
    } mcfg_t;

    mcfg_t cur [4];
    mcfg_t prv [4];
    int    ecnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ecnt <= 0;
            for (int i = 0; i < 4; i++) begin
                cur[i] <= '0;
                prv[i] <= '0;
            end
        end else begin
            ecnt <= ecnt + 1;
            if (cfg4_we) begin
                prv[cfg4_ch] <= cur[cfg4_ch];
                cur[cfg4_ch] <= '{mode: cfg4_mode, period: cfg4_period, duty: cfg4_duty, w: ecnt + 1};
            end
        end
    end

    // Ticks land on edges that are multiples of P4 after reset release; t counts those
    // strictly after the write edge and up to edge e-1, since led trails the state by one clock.
    function automatic logic eval_cfg(input mcfg_t c, input int e);
        int t;
        int pe;
        pe = (c.period == 8'd0) ? 1 : int'(c.period);
        t  = (e - 1) / P4 - c.w / P4;
        case (c.mode)
            2'd1:    return 1'b1;
            2'd2:    return ((t / pe) % 2) == 1;
            2'd3:    return (t % pe) < int'(c.duty);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] model_led();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) begin
            v[i] = eval_cfg((ecnt == cur[i].w) ? prv[i] : cur[i], ecnt);
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Advance to the next falling edge and compare dut4 against the model.
    task automatic cycle();
        logic [3:0] exp;
        @(negedge clk);
        exp = model_led();
        check("model_led4", 32'(led4), 32'(exp));
    endtask

    task automatic wr4(input int ch, input logic [1:0] m, input int per, input int duty);
        cfg4_we     = 1'b1;
        cfg4_ch     = 2'(ch);
        cfg4_mode   = m;
        cfg4_period = 8'(per);
        cfg4_duty   = 8'(duty);
        cycle();
        cfg4_we     = 1'b0;
    endtask

    task automatic wr1(input int ch, input logic [1:0] m, input int per, input int duty);
        cfg1_we     = 1'b1;
        cfg1_ch     = 3'(ch);
        cfg1_mode   = m;
        cfg1_period = 8'(per);
        cfg1_duty   = 8'(duty);
        cycle();
        cfg1_we     = 1'b0;
    endtask

    task automatic cycles_to_change(input int idx, output int n);
        logic v0;
        v0 = led4[idx];
        n  = 0;
        while (n < 100) begin
            cycle();
            n++;
            if (led4[idx] !== v0) break;
        end
    endtask

    task automatic wait_level(input int idx, input logic val, input string name);
        int n;
        n = 0;
        while (led4[idx] !== val && n < 100) begin
            cycle();
            n++;
        end
        check(name, 32'(led4[idx]), 32'(val));
    endtask

    typedef struct {
        int         ch;
        logic [1:0] mode;
        int         period;
        int         duty;
        int         exp_high;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int n;
        int high;

        vecs[0]  = '{2, LED_ON,    0, 0, 48};
        vecs[1]  = '{2, LED_OFF,   0, 0, 0};
        vecs[2]  = '{0, LED_BLINK, 3, 0, 24};
        vecs[3]  = '{0, LED_BLINK, 0, 0, 24};
        vecs[4]  = '{1, LED_PWM,   4, 1, 12};
        vecs[5]  = '{1, LED_PWM,   4, 0, 0};
        vecs[6]  = '{1, LED_PWM,   4, 9, 48};
        vecs[7]  = '{1, LED_PWM,   4, 2, 24};
        vecs[8]  = '{1, LED_PWM,   4, 4, 48};
        vecs[9]  = '{3, LED_PWM,   3, 1, 16};
        vecs[10] = '{3, LED_BLINK, 2, 0, 24};
        vecs[11] = '{3, LED_PWM,   0, 1, 48};

        cfg4_we = 1'b0; cfg4_ch = '0; cfg4_mode = '0; cfg4_period = '0; cfg4_duty = '0;
        cfg1_we = 1'b0; cfg1_ch = '0; cfg1_mode = '0; cfg1_period = '0; cfg1_duty = '0;

        repeat (3) @(negedge clk);
        check("reset_led4", 32'(led4), 32'h0);
        check("reset_led1", 32'(led1), 32'h0);
        rst = 1'b0;
        repeat (8) cycle();

        // ON/OFF latency on ch2: old value after the capture edge, new value one edge later.
        wr4(2, LED_ON, 0, 0);
        check("on_capture_edge", 32'(led4), 32'h0);
        cycle();
        check("on_next_edge", 32'(led4), 32'h4);
        wr4(2, LED_OFF, 0, 0);
        check("off_capture_edge", 32'(led4), 32'h4);
        cycle();
        check("off_next_edge", 32'(led4), 32'h0);

        // BLINK period 3: first rise 10..13 clocks after the write, then 12-clock half periods.
        wr4(0, LED_BLINK, 3, 0);
        cycles_to_change(0, n);
        checks++;
        if (n < 10 || n > 13) begin
            errors++;
            $display("FAIL blink_first_toggle got=%0d exp=10..13", n);
        end
        cycles_to_change(0, n);
        check("blink3_high_run", 32'(n), 32'd12);
        cycles_to_change(0, n);
        check("blink3_low_run", 32'(n), 32'd12);

        wr4(0, LED_BLINK, 0, 0);
        repeat (10) cycle();
        cycles_to_change(0, n);
        cycles_to_change(0, n);
        check("blink0_run_a", 32'(n), 32'd4);
        cycles_to_change(0, n);
        check("blink0_run_b", 32'(n), 32'd4);

        // PWM period 4 duty 1: high for 4 of every 16 clocks.
        wr4(1, LED_PWM, 4, 1);
        repeat (20) cycle();
        wait_level(1, 1'b0, "pwm_sync_low");
        wait_level(1, 1'b1, "pwm_sync_high");
        cycles_to_change(1, n);
        check("pwm_high_run", 32'(n), 32'd4);
        cycles_to_change(1, n);
        check("pwm_low_run", 32'(n), 32'd12);

        // Table: high clocks of the target channel over a 48-clock window.
        for (int v = 0; v < 12; v++) begin
            wr4(vecs[v].ch, vecs[v].mode, vecs[v].period, vecs[v].duty);
            repeat (40) cycle();
            high = 0;
            repeat (48) begin
                cycle();
                high += int'(led4[vecs[v].ch]);
            end
            check($sformatf("vec%0d_high", v), 32'(high), 32'(vecs[v].exp_high));
        end

        // Five-channel instance: invalid indices are dropped, valid ones still land.
        for (int c = 0; c < 5; c++) wr1(c, LED_ON, 0, 0);
        cycle();
        check("dut1_all_on", 32'(led1), 32'h1f);
        wr1(5, LED_OFF, 0, 0);
        wr1(7, LED_OFF, 0, 0);
        cycle();
        check("dut1_bad_ch", 32'(led1), 32'h1f);
        wr1(4, LED_OFF, 0, 0);
        cycle();
        check("dut1_ch4_off", 32'(led1), 32'h0f);

        // PRESCALE=1 ticks every clock: BLINK period 1 alternates each cycle.
        wr1(1, LED_BLINK, 1, 0);
        cycle();
        check("p1_blink_a", 32'(led1[1]), 32'h0);
        cycle();
        check("p1_blink_b", 32'(led1[1]), 32'h1);
        cycle();
        check("p1_blink_c", 32'(led1[1]), 32'h0);

        // Rewriting BLINK period 3 every 3 clocks collides with the wrap tick each time.
        wr1(0, LED_BLINK, 3, 0);
        cycle();
        cycle();
        for (int i = 0; i < 20; i++) begin
            wr1(0, LED_BLINK, 3, 0);
            check("tick_write_w", 32'(led1[0]), 32'h0);
            cycle();
            check("tick_write_1", 32'(led1[0]), 32'h0);
            cycle();
            check("tick_write_2", 32'(led1[0]), 32'h0);
        end
        cycle();
        check("tick_release_3", 32'(led1[0]), 32'h0);
        cycle();
        check("tick_release_4", 32'(led1[0]), 32'h1);

        // Reset mid-run: outputs drop asynchronously and stay off after release.
        for (int c = 0; c < 4; c++) wr4(c, LED_ON, 0, 0);
        cycle();
        check("all_on_before_rst", 32'(led4), 32'hf);
        #2 rst = 1'b1;
        #1;
        check("rst_async_led4", 32'(led4), 32'h0);
        check("rst_async_led1", 32'(led1), 32'h0);
        repeat (10) cycle();
        rst = 1'b0;
        repeat (1000) cycle();
        check("post_rst_led4", 32'(led4), 32'h0);
        check("post_rst_led1", 32'(led1), 32'h0);

        // All four channels in different modes, tracked by the model every cycle.
        wr4(0, LED_BLINK, 5, 0);
        wr4(1, LED_PWM, 7, 3);
        wr4(2, LED_ON, 0, 0);
        wr4(3, LED_OFF, 9, 9);
        repeat (5000) cycle();
        wr4(3, LED_PWM, 6, 4);
        repeat (5000) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
